fifo_rd_stream: RTL

- Read-side stage that sits directly downstream of the synchronous FIFO.
- Drains the FIFO through its fifo_read / fifo_empty / fifo_data_out interface and presents the words on a valid/ready stream.
- Absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, so the stream sustains one word per cycle with no bubbles.
- Keeps a saturating count of words delivered downstream.

---
 rtl/fifo_rd_stream.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the synchronous FIFO: absorbs the FIFO's one-cycle
// read latency in a 2-entry buffer and presents the words on a valid/ready stream.

module fifo_rd_stream #(
  parameter int width     = 16,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [width-1:0]     fifo_data_out,
  output logic                 fifo_read,
  output logic [width-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [cnt_width-1:0] words_out
);

  logic [1:0]           occ_r;
  logic [1:0]           occ_next_s;
  logic                 inflight_r;
  logic                 valid_r;
  logic                 pop_s;
  logic [2:0]           credit_s;
  logic [width-1:0]     head_r;
  logic [width-1:0]     tail_r;
  logic [width-1:0]     head_next_s;
  logic [width-1:0]     tail_next_s;
  logic [cnt_width-1:0] words_r;
  logic [cnt_width-1:0] words_next_s;

  // Handshake and read credit: occupancy after this edge counts the word already in flight.
  always_comb begin
    pop_s      = valid_r && out_ready;
    credit_s   = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    occ_next_s = credit_s[1:0];
    fifo_read  = rst_ && en && !fifo_empty && (credit_s < 3'd2);
  end

  // Buffer steering: a returning word lands in head when head is free or being popped, else in tail.
  always_comb begin
    head_next_s = head_r;
    tail_next_s = tail_r;
    if (inflight_r) begin
      case (occ_r)
        2'd0: begin
          head_next_s = fifo_data_out;
        end
        2'd1: begin
          if (pop_s) begin
            head_next_s = fifo_data_out;
          end else begin
            tail_next_s = fifo_data_out;
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_next_s = tail_r;
            tail_next_s = fifo_data_out;
          end else begin
            head_next_s = head_r;
          end
        end
        default: begin
          head_next_s = head_r;
        end
      endcase
    end else if (pop_s) begin
      head_next_s = tail_r;
    end else begin
      head_next_s = head_r;
    end
  end

  // Delivered-word counter saturates at all-ones.
  always_comb begin
    if (pop_s && (words_r != {cnt_width{1'b1}})) begin
      words_next_s = words_r + {{(cnt_width-1){1'b0}}, 1'b1};
    end else begin
      words_next_s = words_r;
    end
  end

  // State registers; clearing inflight on reset drops any word returning just after it.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      valid_r    <= 1'b0;
      head_r     <= {width{1'b0}};
      tail_r     <= {width{1'b0}};
      words_r    <= {cnt_width{1'b0}};
    end else begin
      occ_r      <= occ_next_s;
      inflight_r <= fifo_read;
      valid_r    <= (occ_next_s != 2'd0);
      head_r     <= head_next_s;
      tail_r     <= tail_next_s;
      words_r    <= words_next_s;
    end
  end

  assign out_data  = head_r;
  assign out_valid = valid_r;
  assign words_out = words_r;

  fifo_rd_stream_chk u_chk (
    .clk        (clk),
    .rst_       (rst_),
    .inflight   (inflight_r),
    .pop        (pop_s),
    .fifo_read  (fifo_read),
    .fifo_empty (fifo_empty),
    .occ        (occ_r)
  );

endmodule

// Protocol checker for fifo_rd_stream: buffer overflow, occupancy range and
// reads of an empty FIFO are all design errors.
module fifo_rd_stream_chk (
  input logic       clk,
  input logic       rst_,
  input logic       inflight,
  input logic       pop,
  input logic       fifo_read,
  input logic       fifo_empty,
  input logic [1:0] occ
);

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_) !(inflight && (occ == 2'd2) && !pop));
  a_occ_range:    assert property (@(posedge clk) disable iff (!rst_) (occ <= 2'd2));
  a_no_underflow: assert property (@(posedge clk) !(fifo_read && fifo_empty));

endmodule
